// File: rtl/hermes_flit_injector.sv
// rtl/hermes_flit_injector.sv - Hermes link packet injector: header, size, payload flits under credit flow control.
// Optional link stall counter enabled by HERMES_INJECTOR_STALL_CNT_EN.
module hermes_flit_injector #(
  parameter int FLIT_SIZE = 32,
  parameter int SIZE_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [FLIT_SIZE-1:0] cmd_header_i,
  input  logic [FLIT_SIZE-1:0] cmd_size_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [FLIT_SIZE-1:0] pl_data_i,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [31:0]          stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, SIZE, PAYLOAD} state_e;

  state_e                 state_q, state_d;
  logic [SIZE_W-1:0]      cnt_q, cnt_d;
  logic [SIZE_W-1:0]      size_q, size_d;
  logic                   tx_q, tx_d;
  logic [FLIT_SIZE-1:0]   data_q, data_d;
  logic                   err_q, err_d;
  logic                   rdy_q;
  logic                   load_en, cmd_fire, pl_fire, size_ok;
  logic [FLIT_SIZE-1:0]   size_hi;

  assign load_en  = !tx_q || credit_i;
  assign size_hi  = cmd_size_i >> SIZE_W;
  assign size_ok  = (size_hi == '0) && (cmd_size_i != '0);

  // rdy_q keeps cmd_ready_o low while reset is held and until the first clock after release.
  assign cmd_ready_o = rdy_q && (state_q == IDLE) && load_en;
  assign pl_ready_o  = (state_q == PAYLOAD) && load_en;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign pl_fire     = pl_valid_i && pl_ready_o;

  assign tx_o   = tx_q;
  assign data_o = data_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE) || tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    tx_d    = tx_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (load_en) tx_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (size_ok) begin
            tx_d    = 1'b1;
            data_d  = cmd_header_i;
            cnt_d   = cmd_size_i[SIZE_W-1:0];
            size_d  = cmd_size_i[SIZE_W-1:0];
            state_d = SIZE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SIZE: begin
        if (load_en) begin
          tx_d    = 1'b1;
          data_d  = FLIT_SIZE'(size_q);
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pl_fire) begin
          tx_d   = 1'b1;
          data_d = pl_data_i;
          cnt_d  = cnt_q - SIZE_W'(1);
          if (cnt_q == SIZE_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      tx_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef HERMES_INJECTOR_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (tx_q && !credit_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hermes_flit_injector.sv
// tb/tb_hermes_flit_injector.sv - self-checking bench for hermes_flit_injector.
module tb_hermes_flit_injector;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [FW-1:0] cmd_header = '0, cmd_size = '0;
  logic          pl_valid = 1'b0, pl_ready;
  logic [FW-1:0] pl_data = '0;
  logic          tx, busy, err;
  logic [FW-1:0] data;
  logic          credit = 1'b1;
  logic [31:0]   stall_cnt;

  hermes_flit_injector #(.FLIT_SIZE(FW), .SIZE_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_header_i(cmd_header), .cmd_size_i(cmd_size),
    .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_data_i(pl_data),
    .tx_o(tx), .data_o(data), .credit_i(credit),
    .busy_o(busy), .err_o(err), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int base;
  bit credit_rand = 1'b0, credit_force = 1'b1;

  logic [FW-1:0] cmd_hq[$], cmd_sq[$], pl_q[$];
  int            cmd_rd = 0, pl_rd = 0;
  logic [FW-1:0] exp_q[$], pl_buf[$];
  logic [FW-1:0] got_q[$];
  int            got_cyc[$];
  int            err_n = 0, tx_n = 0, fire_cyc = 0;
  bit            cmd_fire_n = 1'b0, pl_fire_n = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: records every transferred flit and event counts, sampled mid-cycle.
  always @(negedge clk) begin
    cmd_fire_n = rst_ni && cmd_valid && cmd_ready;
    pl_fire_n  = rst_ni && pl_valid && pl_ready;
    if (rst_ni) begin
      if (cmd_fire_n) fire_cyc = cyc;
      if (err) err_n++;
      if (tx) tx_n++;
      if (tx && credit) begin
        got_q.push_back(data);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Command and payload sources; anything queued while in reset is discarded.
  always @(posedge clk) begin
    #1;
    if (!rst_ni) begin
      cmd_rd = cmd_hq.size();
      pl_rd  = pl_q.size();
    end else begin
      if (cmd_fire_n) cmd_rd++;
      if (pl_fire_n) pl_rd++;
    end
    cmd_valid  = rst_ni && (cmd_rd < cmd_hq.size());
    cmd_header = cmd_valid ? cmd_hq[cmd_rd] : '0;
    cmd_size   = cmd_valid ? cmd_sq[cmd_rd] : '0;
    pl_valid   = rst_ni && (pl_rd < pl_q.size());
    pl_data    = pl_valid ? pl_q[pl_rd] : '0;
  end

  always @(posedge clk) begin
    #2;
    credit = credit_rand ? ($urandom_range(0, 3) != 0) : credit_force;
  end

  // Reference model: a packet is header, size, then its payload words; bad sizes produce nothing.
  task automatic push_pkt(input logic [FW-1:0] h, input logic [FW-1:0] s);
    cmd_hq.push_back(h);
    cmd_sq.push_back(s);
    if (s >= 1 && s < 32'h0001_0000) begin
      exp_q.push_back(h);
      exp_q.push_back(s);
      for (int i = 0; i < int'(s); i++) begin
        exp_q.push_back(pl_buf[i]);
        pl_q.push_back(pl_buf[i]);
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cmd_rd == cmd_hq.size() && pl_rd == pl_q.size() && !busy &&
          (got_q.size() - base) >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (tx !== 1'b0 || data !== '0) begin n_fail++; $display("FAIL reset_link tx=%b data=%h want 0/0", tx, data); end
    n_chk++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b err=%b want 0/0", busy, err); end
    n_chk++; if (cmd_ready !== 1'b0 || pl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready cmd=%b pl=%b want 0/0", cmd_ready, pl_ready); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", cmd_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    exp_q.delete(); base = got_q.size();
    pl_buf = '{32'hA, 32'hB, 32'hC};
    push_pkt(32'h0000_0101, 32'd3);
    wait_done(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got %0d flits want %0d", got_q.size() - base, exp_q.size()); end
    n_chk++; if (got_q.size() - base != 5) begin n_fail++; $display("FAIL basic_count got %0d want 5", got_q.size() - base); end
    for (int i = 0; i < 5 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
    if (got_q.size() - base == 5) begin
      n_chk++; if (got_cyc[base+4] - got_cyc[base] != 4) begin n_fail++; $display("FAIL basic_spacing span %0d want 4", got_cyc[base+4] - got_cyc[base]); end
      n_chk++; if (got_cyc[base] != fire_cyc + 1) begin n_fail++; $display("FAIL basic_latency header cyc %0d want %0d", got_cyc[base], fire_cyc + 1); end
    end
    n_chk++; if (tx !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle tx=%b busy=%b want 0/0", tx, busy); end
  endtask

  task automatic test_stall();
    bit ok, found;
    logic [31:0] st0, exp_st;
    exp_q.delete(); base = got_q.size(); st0 = stall_cnt; found = 1'b0;
    pl_buf = '{32'hA, 32'hB, 32'hC};
    push_pkt(32'h0000_0101, 32'd3);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx && data == 32'd3) begin found = 1'b1; credit_force = 1'b0; break; end
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL stall_size_seen got none want size flit 3"); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (tx !== 1'b1 || data !== 32'd3) begin n_fail++; $display("FAIL stall_hold%0d tx=%b data=%h want 1/3", i, tx, data); end
    end
    @(posedge clk); #1; credit_force = 1'b1;
    wait_done(200, ok);
    n_chk++; if (!ok || got_q.size() - base != 5) begin n_fail++; $display("FAIL stall_count got %0d want 5", got_q.size() - base); end
    for (int i = 0; i < 5 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
`ifdef HERMES_INJECTOR_STALL_CNT_EN
    exp_st = 32'd4;
`else
    exp_st = 32'd0;
`endif
    n_chk++; if (stall_cnt - st0 !== exp_st) begin n_fail++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt - st0, exp_st); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_q.delete(); base = got_q.size();
    pl_buf = '{$urandom};
    push_pkt($urandom, 32'd1);
    pl_buf = '{$urandom, $urandom};
    push_pkt($urandom, 32'd2);
    wait_done(200, ok);
    n_chk++; if (!ok || got_q.size() - base != 7) begin n_fail++; $display("FAIL b2b_count got %0d want 7", got_q.size() - base); end
    for (int i = 0; i < 7 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
    if (got_q.size() - base == 7) begin
      n_chk++; if (got_cyc[base+6] - got_cyc[base] != 6) begin n_fail++; $display("FAIL b2b_gap span %0d want 6", got_cyc[base+6] - got_cyc[base]); end
    end
  endtask

  task automatic test_error();
    bit ok;
    int e0, t0;
    logic [FW-1:0] bad[2];
    bad[0] = 32'd0; bad[1] = 32'h0001_0000;
    for (int k = 0; k < 2; k++) begin
      exp_q.delete(); base = got_q.size(); e0 = err_n; t0 = tx_n;
      push_pkt($urandom, bad[k]);
      wait_done(50, ok);
      repeat (3) @(negedge clk);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL err%0d_handshake got no accept want accept", k); end
      n_chk++; if (err_n - e0 != 1) begin n_fail++; $display("FAIL err%0d_pulse got %0d cycles want 1", k, err_n - e0); end
      n_chk++; if (tx_n - t0 != 0) begin n_fail++; $display("FAIL err%0d_link got %0d tx cycles want 0", k, tx_n - t0); end
    end
    exp_q.delete(); base = got_q.size();
    pl_buf = '{$urandom, $urandom};
    push_pkt(32'h0000_0202, 32'd2);
    wait_done(200, ok);
    n_chk++; if (!ok || got_q.size() - base != 4) begin n_fail++; $display("FAIL err_next_count got %0d want 4", got_q.size() - base); end
    for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL err_next_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_starve();
    bit ok, found;
    logic [FW-1:0] w[4];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    exp_q.delete(); base = got_q.size(); found = 1'b0;
    exp_q = '{32'h0000_0404, 32'd4, w[0], w[1], w[2], w[3]};
    cmd_hq.push_back(32'h0000_0404); cmd_sq.push_back(32'd4);
    pl_q.push_back(w[0]);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pl_valid && pl_ready) begin found = 1'b1; break; end
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL starve_first got no payload accept want accept"); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_chk++; if (tx !== 1'b0 || pl_ready !== 1'b1) begin n_fail++; $display("FAIL starve_gap%0d tx=%b pl_ready=%b want 0/1", i, tx, pl_ready); end
      end
    end
    for (int i = 1; i < 4; i++) pl_q.push_back(w[i]);
    wait_done(200, ok);
    n_chk++; if (!ok || got_q.size() - base != 6) begin n_fail++; $display("FAIL starve_count got %0d want 6", got_q.size() - base); end
    for (int i = 0; i < 6 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL starve_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    exp_q.delete(); base = got_q.size();
    credit_rand = 1'b1;
    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 5);
      pl_buf.delete();
      for (int i = 0; i < n; i++) pl_buf.push_back($urandom);
      push_pkt($urandom, n);
    end
    wait_done(2000, ok);
    credit_rand = 1'b0;
    n_chk++; if (!ok || got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    logic [FW-1:0] h;
    h = 32'h0000_0808; found = 1'b0;
    exp_q.delete(); base = got_q.size();
    pl_buf.delete();
    for (int i = 0; i < 8; i++) pl_buf.push_back($urandom);
    push_pkt(h, 32'd8);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx && data == h) begin found = 1'b1; break; end
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL rstmid_header got none want header on link"); end
    #2 rst_ni = 1'b0;
    #1;
    n_chk++; if (tx !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_async tx=%b busy=%b cmd_ready=%b want 0/0/0", tx, busy, cmd_ready); end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    exp_q.delete(); base = got_q.size();
    pl_buf = '{$urandom};
    push_pkt(32'h0000_0909, 32'd1);
    wait_done(200, ok);
    n_chk++; if (!ok || got_q.size() - base != 3) begin n_fail++; $display("FAIL rstmid_count got %0d want 3", got_q.size() - base); end
    for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
      n_chk++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_flit%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_error();
    test_starve();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
